// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: states, opcodes,
// mux select codes and the packed control word produced per state.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MREAD  = 4'd3,
        S_WBLD   = 4'd4,
        S_MWRITE = 4'd5,
        S_EXR    = 4'd6,
        S_WBR    = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_EXI    = 4'd10,
        S_WBI    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    localparam logic [1:0] SRC_B_REG    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic isLegalOp(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mcycle_ctrl_decode.sv
// Pure state -> control word table; enables here are raw and get run-gated by the parent.
module mcycle_ctrl_decode
    import mcpu_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // Anything not set for a state stays 0, including unreachable codes.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRC_B_FOUR;
                ctrl_o.alu_op    = ALU_OP_ADD;
                ctrl_o.pc_source = PC_SRC_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRC_B_IMM_SH;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_MADDR, S_EXI: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_MREAD: begin
                ctrl_o.i_or_d = 1'b1;
            end
            S_WBLD: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MWRITE: begin
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_REG;
                ctrl_o.alu_op    = ALU_OP_FUNCT;
            end
            S_WBR: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRC_B_REG;
                ctrl_o.alu_op        = ALU_OP_SUB;
                ctrl_o.pc_source     = PC_SRC_ALUOUT;
                ctrl_o.pc_write_cond = 1'b1;
            end
            S_JMP: begin
                ctrl_o.pc_source = PC_SRC_JUMP;
                ctrl_o.pc_write  = 1'b1;
            end
            S_WBI: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcycle_ctrl_fsm.sv
// Moore control FSM for the multi-cycle CPU: state register, opcode-driven sequencing,
// and run/reset gating of every write-enable (selects pass through ungated).
module mcycle_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            pc_en,
    output logic            i_or_d,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic [ST_W-1:0] state,
    output logic            illegal
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   enGate;

    mcycle_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Unreachable codes recover to FETCH even while the debug unit holds run low.
    always_comb begin
        state_d = state_q;
        if (state_q > S_WBI) begin
            state_d = S_FETCH;
        end else if (run) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MADDR;
                        OP_RTYPE:     state_d = S_EXR;
                        OP_ADDI:      state_d = S_EXI;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_J:         state_d = S_JMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MADDR: begin
                    if (opcode == OP_LW) begin
                        state_d = S_MREAD;
                    end else if (opcode == OP_SW) begin
                        state_d = S_MWRITE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_MREAD:  state_d = S_WBLD;
                S_EXR:    state_d = S_WBR;
                S_EXI:    state_d = S_WBI;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    // Reset also kills enables so an interrupted instruction cannot commit.
    always_comb begin
        enGate     = run & ~rst;
        pc_en      = enGate & (ctrl.pc_write | (ctrl.pc_write_cond & zero));
        ir_write   = enGate & ctrl.ir_write;
        mem_write  = enGate & ctrl.mem_write;
        reg_write  = enGate & ctrl.reg_write;
        illegal    = enGate & (state_q == S_DECODE) & ~isLegalOp(opcode);
        i_or_d     = ctrl.i_or_d;
        reg_dst    = ctrl.reg_dst;
        mem_to_reg = ctrl.mem_to_reg;
        alu_src_a  = ctrl.alu_src_a;
        alu_src_b  = ctrl.alu_src_b;
        alu_op     = ctrl.alu_op;
        pc_source  = ctrl.pc_source;
        state      = ST_W'(state_q);
    end

endmodule

// File: tb/tb_mcycle_ctrl_fsm.sv
// Bench for mcycle_ctrl_fsm: directed scenarios then random run/zero/reset/opcode traffic,
// checked against a per-instruction state-path model.
module tb_mcycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       zero = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int total = 0;
    int bad = 0;
    int expState = -1;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010;

    // Full state visit order per instruction class; -1 ends the path.
    int paths [7][6] = '{
        '{0, 1, 6, 7, -1, -1},
        '{0, 1, 10, 11, -1, -1},
        '{0, 1, 2, 3, 4, -1},
        '{0, 1, 2, 5, -1, -1},
        '{0, 1, 8, -1, -1, -1},
        '{0, 1, 9, -1, -1, -1},
        '{0, 1, -1, -1, -1, -1}
    };

    mcycle_ctrl_fsm #(.OP_W(6), .ST_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic int opClass(input logic [5:0] op);
        case (op)
            RT:      return 0;
            ADDI:    return 1;
            LW:      return 2;
            SW:      return 3;
            BEQ:     return 4;
            JMP:     return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int nextState(input int s, input logic [5:0] op);
        int c = opClass(op);
        for (int i = 0; i < 5; i++) begin
            if (paths[c][i] == s) return (paths[c][i+1] < 0) ? 0 : paths[c][i+1];
        end
        return 0;
    endfunction

    // {i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source}
    function automatic logic [10:0] expSel(input int s);
        logic iod = 0, rdst = 0, m2r = 0, sa = 0;
        logic [1:0] sb = 0, op = 0, pcs = 0;
        case (s)
            0:  sb = 2'd1;
            1:  sb = 2'd3;
            2, 10: begin sa = 1; sb = 2'd2; end
            3, 5:  iod = 1;
            4:  m2r = 1;
            6:  begin sa = 1; op = 2'd2; end
            7:  rdst = 1;
            8:  begin sa = 1; op = 2'd1; pcs = 2'd1; end
            9:  pcs = 2'd2;
            default: ;
        endcase
        return {iod, rdst, m2r, sa, sb, op, pcs};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check at negedge, advance model at posedge.
    task automatic applyStimulus(input logic r, input logic rn, input logic z, input logic [5:0] op);
        logic       gate;
        logic [4:0] expEn;
        rst = r; run = rn; zero = z; opcode = op;
        @(negedge clk);
        gate = rn && !r;
        expEn = {gate && (expState == 0 || expState == 9 || (expState == 8 && z)),
                 gate && expState == 0,
                 gate && expState == 5,
                 gate && (expState == 4 || expState == 7 || expState == 11),
                 gate && expState == 1 && opClass(op) == 6};
        checkOutput("enables", 16'({pc_en, ir_write, mem_write, reg_write, illegal}), 16'(expEn));
        if (expState >= 0) begin
            checkOutput("state", 16'(state), 16'(expState));
            checkOutput("selects", 16'({i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                                        alu_op, pc_source}), 16'(expSel(expState)));
        end
        @(posedge clk);
        if (r) expState = 0;
        else if (rn && expState >= 0) expState = nextState(expState, op);
        #1;
    endtask

    initial begin
        logic [5:0] curOp;
        logic [5:0] opTab [6] = '{RT, ADDI, LW, SW, BEQ, JMP};
        int k;

        applyStimulus(1, 1, 0, RT);
        repeat (5) applyStimulus(0, 1, 0, LW);
        repeat (3) applyStimulus(0, 1, 1, BEQ);
        repeat (3) applyStimulus(0, 1, 0, BEQ);
        repeat (3) applyStimulus(0, 1, 0, SW);
        repeat (3) applyStimulus(0, 0, 0, SW);
        repeat (2) applyStimulus(0, 1, 0, SW);
        repeat (3) applyStimulus(0, 1, 0, 6'b111111);
        repeat (3) applyStimulus(0, 1, 0, RT);
        applyStimulus(1, 1, 0, RT);
        repeat (4) applyStimulus(0, 1, 0, RT);
        repeat (4) applyStimulus(0, 1, 0, JMP);
        repeat (4) applyStimulus(0, 1, 1, ADDI);

        curOp = RT;
        for (int i = 0; i < 800; i++) begin
            if (expState == 0) begin
                k = $urandom_range(0, 6);
                if (k < 6) begin
                    curOp = opTab[k];
                end else begin
                    curOp = 6'($urandom);
                    if (opClass(curOp) != 6) curOp = 6'b111111;
                end
            end
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                          1'($urandom_range(0, 1)), curOp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
